data_mem_responder: RTL and testbench

- Responder end of the memory-stage data interface: it accepts the request bundle from the MEM stage and services it against an internal byte-addressable RAM.
- Request bundle: mreq, write, addr, access_size, wr_data.
- Adds a fixed, parameterised wait-state latency, a one-cycle ready pulse, byte-lane steering for byte/half/word accesses, and an error flag for bad accesses.
- Sits between the MEM stage and the data RAM; the MEM stage holds its request stable until ready.

---
 rtl/data_mem_responder.sv | 156 +++++++++++++++
 tb/tb_data_mem_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - MEM-stage data responder with wait states, lane steering and fault flag
module data_mem_responder #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mreq,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [1:0]  access_size,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        ready,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        write_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic [31:0] wr_data_q;
    logic        err_q;

    logic [31:0] ram [0:(1 << ADDR_WIDTH) - 1];

    logic        acc_err;
    logic [31:0] sel_addr;
    logic [1:0]  sel_size;
    logic [31:0] rd_next;
    logic [3:0]  wmask;
    logic [31:0] wbytes;

    // Misaligned, reserved-size or out-of-window accesses are rejected; the
    // unsigned subtract makes addresses below BASE_ADDR wrap and fault too.
    function automatic logic bad_access(input logic [31:0] a, input logic [1:0] s);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return (s == 2'b11) ||
               (s == 2'b01 && a[0]) ||
               (s == 2'b10 && a[1:0] != 2'b00) ||
               ({1'b0, off} >= (33'd4 << ADDR_WIDTH));
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] word_index(input logic [31:0] a);
        return ADDR_WIDTH'((a - BASE_ADDR) >> 2);
    endfunction

    // Right-align the addressed lane(s) and zero-extend.
    function automatic logic [31:0] load_lanes(input logic [31:0] w, input logic [1:0] lane,
                                               input logic [1:0] s);
        case (s)
            2'b00:   return {24'b0, w[{lane, 3'b000} +: 8]};
            2'b01:   return lane[1] ? {16'b0, w[31:16]} : {16'b0, w[15:0]};
            default: return w;
        endcase
    endfunction

    // With LATENCY==1 the response is formed straight from the inputs in IDLE;
    // otherwise from the latched request at the end of WAIT.
    always_comb begin
        acc_err  = bad_access(addr, access_size);
        sel_addr = (state == IDLE) ? addr : addr_q;
        sel_size = (state == IDLE) ? access_size : size_q;
        rd_next  = load_lanes(ram[word_index(sel_addr)], sel_addr[1:0], sel_size);
    end

    // Store lane enables and replicated store data for the latched request.
    always_comb begin
        wmask  = 4'b0000;
        wbytes = wr_data_q;
        case (size_q)
            2'b00: begin
                wmask  = 4'b0001 << addr_q[1:0];
                wbytes = {4{wr_data_q[7:0]}};
            end
            2'b01: begin
                wmask  = addr_q[1] ? 4'b1100 : 4'b0011;
                wbytes = {2{wr_data_q[15:0]}};
            end
            2'b10:   wmask = 4'b1111;
            default: wmask = 4'b0000;
        endcase
    end

    // Request FSM with registered ready/err/rd_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            ready     <= 1'b0;
            err       <= 1'b0;
            rd_data   <= 32'd0;
            write_q   <= 1'b0;
            addr_q    <= 32'd0;
            size_q    <= 2'b00;
            wr_data_q <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (mreq) begin
                        write_q   <= write;
                        addr_q    <= addr;
                        size_q    <= access_size;
                        wr_data_q <= wr_data;
                        err_q     <= acc_err;
                        if (LATENCY == 1) begin
                            state <= RESP;
                            ready <= 1'b1;
                            err   <= acc_err;
                            if (acc_err)
                                rd_data <= 32'd0;
                            else if (!write)
                                rd_data <= rd_next;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                        ready <= 1'b1;
                        err   <= err_q;
                        if (err_q)
                            rd_data <= 32'd0;
                        else if (!write_q)
                            rd_data <= rd_next;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Stores commit at the edge that ends the response cycle, addressed lanes only.
    always_ff @(posedge clk) begin
        if (!rst && state == RESP && write_q && !err_q) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i])
                    ram[word_index(addr_q)][8*i +: 8] <= wbytes[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized scoreboard bench for data_mem_responder
module tb_data_mem_responder;

    localparam int LAT = 2;
    localparam int AW  = 12;
    localparam int RAM_BYTES = 4 << AW;

    logic        clk = 1'b0;
    logic        rst;
    logic        mreq, mreq1;
    logic        write;
    logic [31:0] addr;
    logic [1:0]  access_size;
    logic [31:0] wr_data;
    logic [31:0] rd_data, rd_data1;
    logic        ready, ready1;
    logic        err, err1;

    data_mem_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(32'h0), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .mreq(mreq), .write(write), .addr(addr),
        .access_size(access_size), .wr_data(wr_data),
        .rd_data(rd_data), .ready(ready), .err(err)
    );

    data_mem_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(32'h0), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .mreq(mreq1), .write(write), .addr(addr),
        .access_size(access_size), .wr_data(wr_data),
        .rd_data(rd_data1), .ready(ready1), .err(err1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rd;
    } exp_t;
    exp_t sbq[$];

    logic [7:0]  mem_m [0:RAM_BYTES-1];
    logic [31:0] last_rd = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT signals ready.
    always @(negedge clk) begin
        if (!rst) begin
            if (ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: ready=1 with no outstanding request (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("ready_cycle", cyc, e.cyc);
                    check("err", {31'b0, err}, {31'b0, e.err});
                    check("rd_data", rd_data, e.rd);
                end
            end else begin
                check("err_without_ready", {31'b0, err}, 32'd0);
            end
        end
    end

    // Reference model: byte array, alignment/range rules, response of a request.
    task automatic model(input logic w, input logic [31:0] a, input logic [1:0] s,
                         input logic [31:0] d, output logic e, output logic [31:0] rd);
        int nb;
        nb = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
        e = (s == 2'b11) || (a % nb != 0) || (a >= RAM_BYTES);
        rd = 32'd0;
        if (!e) begin
            if (w) begin
                for (int k = 0; k < nb; k++) mem_m[a + k] = d[8*k +: 8];
                rd = last_rd;
            end else begin
                for (int k = 0; k < nb; k++) rd[8*k +: 8] = mem_m[a + k];
            end
        end
        last_rd = rd;
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic issue(input logic w, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        exp_t ex;
        logic got;
        model(w, a, s, d, ex.err, ex.rd);
        ex.cyc = cyc + LAT;
        sbq.push_back(ex);
        mreq = 1'b1; write = w; addr = a; access_size = s; wr_data = d;
        got = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready=0 expected 1 for addr %h", a);
        end
        @(posedge clk); #1;
        mreq = 1'b0;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [9:0]  pat;
        logic [9:0]  exp_pat;
        logic [31:0] a;
        rst = 1'b1; mreq = 1'b0; mreq1 = 1'b0; write = 1'b0;
        addr = 32'd0; access_size = 2'b10; wr_data = 32'd0;
        gap(3);
        check("reset_ready", {31'b0, ready}, 32'd0);
        check("reset_err", {31'b0, err}, 32'd0);
        check("reset_rd_data", rd_data, 32'd0);
        rst = 1'b0;
        gap(1);

        // Directed sequence
        issue(1'b1, 32'h100, 2'b10, 32'hDEADBEEF);
        issue(1'b0, 32'h100, 2'b10, 32'h0);
        issue(1'b1, 32'h101, 2'b00, 32'h55);
        issue(1'b0, 32'h100, 2'b10, 32'h0);
        issue(1'b0, 32'h103, 2'b00, 32'h0);
        issue(1'b0, 32'h101, 2'b00, 32'h0);
        issue(1'b0, 32'h102, 2'b01, 32'h0);
        issue(1'b0, 32'h101, 2'b01, 32'h0);
        issue(1'b1, 32'h102, 2'b10, 32'h12345678);
        issue(1'b0, 32'h100, 2'b10, 32'h0);
        issue(1'b0, 32'h4000, 2'b10, 32'h0);
        issue(1'b0, 32'h100, 2'b11, 32'h0);
        issue(1'b1, 32'h3FFC, 2'b10, 32'hA5A5_0F0F);
        issue(1'b0, 32'h3FFC, 2'b10, 32'h0);

        // Reset during WAIT discards a pending store
        mreq = 1'b1; write = 1'b1; addr = 32'h100; access_size = 2'b10; wr_data = 32'h11111111;
        gap(1);
        rst = 1'b1; mreq = 1'b0;
        gap(1);
        rst = 1'b0;
        last_rd = 32'd0;
        check("post_reset_ready", {31'b0, ready}, 32'd0);
        check("post_reset_err", {31'b0, err}, 32'd0);
        check("post_reset_rd_data", rd_data, 32'd0);
        gap(2);
        issue(1'b0, 32'h100, 2'b10, 32'h0);

        // Initialise a window, then randomized traffic over it
        for (int i = 0; i < 32; i++) begin
            issue(1'b1, 32'h200 + 4*i, 2'b10, $urandom);
            gap($urandom_range(0, 1));
        end
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 7) == 0)
                a = 32'h4000 + $urandom_range(0, 255);
            else
                a = 32'h200 + $urandom_range(0, 127);
            issue(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), $urandom);
            gap($urandom_range(0, 2));
        end
        gap(2);
        check("scoreboard_drained", sbq.size(), 32'd0);

        // LATENCY=1: mreq held high for 10 cycles
        write = 1'b0; addr = 32'h100; access_size = 2'b10;
        mreq1 = 1'b1;
        exp_pat = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pat[i] = ready1;
            exp_pat[i] = (i % 2 == 1);
            if (ready1) check("lat1_err", {31'b0, err1}, 32'd0);
        end
        @(posedge clk); #1;
        mreq1 = 1'b0;
        check("lat1_ready_pattern", {22'b0, pat}, {22'b0, exp_pat});
        gap(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
